// File: rtl/gpio_int_ctrl_pkg.sv
// Shared definitions for the GPIO / interrupt controller: bus widths, register
// offsets within the 8-word block, and per-pin mode/polarity encodings.
package gpio_int_ctrl_pkg;

  localparam int XLEN             = 32;
  localparam int MM_REG_ADDR_BITS = 8;

  localparam logic [2:0] GPIO_OUT_OFS   = 3'd0;
  localparam logic [2:0] GPIO_IN_OFS    = 3'd1;
  localparam logic [2:0] INT_EN_OFS     = 3'd2;
  localparam logic [2:0] INT_MODE_OFS   = 3'd3;
  localparam logic [2:0] INT_POL_OFS    = 3'd4;
  localparam logic [2:0] INT_PEND_OFS   = 3'd5;
  localparam logic [2:0] INT_STATUS_OFS = 3'd6;

  typedef enum logic [2:0] {
    REG_GPIO_OUT   = 3'd0,
    REG_GPIO_IN    = 3'd1,
    REG_INT_EN     = 3'd2,
    REG_INT_MODE   = 3'd3,
    REG_INT_POL    = 3'd4,
    REG_INT_PEND   = 3'd5,
    REG_INT_STATUS = 3'd6,
    REG_RSVD       = 3'd7
  } reg_idx_t;

  localparam logic MODE_EDGE       = 1'b1;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  function automatic logic [XLEN-1:0] lane_mask(input logic [XLEN/8-1:0] sel);
    logic [XLEN-1:0] m;
    m = '0;
    for (int i = 0; i < XLEN / 8; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_int_ctrl_sync_edge_detect.sv
// Multi-flop input synchroniser with a one-cycle history flop; exposes the
// synchronised level and its rising/falling transitions.
module sync_edge_detect
  import gpio_int_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_in_s,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] r_in_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
      r_in_d <= '0;
    end else begin
      r_sync[0] <= i_in;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_in_d <= r_sync[STAGES-1];
    end
  end

  assign o_in_s = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_in_d;
  assign o_fall = ~r_sync[STAGES-1] & r_in_d;

endmodule

// File: rtl/gpio_int_ctrl.sv
// Memory-mapped GPIO block with per-pin edge/level interrupts, W1C pending
// latches and a registered aggregate interrupt line.
module gpio_int_ctrl
  import gpio_int_ctrl_pkg::*;
#(
  parameter int          NUM_GPIOS     = 32,
  parameter int          SYNC_STAGES   = 2,
  parameter int          REG_ADDR_BITS = MM_REG_ADDR_BITS,
  parameter int unsigned BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     WB_RD_STB_I,
  input  logic [REG_ADDR_BITS-1:0] WB_RD_ADR_I,
  output logic [XLEN-1:0]          WB_RD_DAT_O,
  output logic                     WB_RD_ACK_O,
  input  logic                     WB_WR_STB_I,
  input  logic                     WB_WR_WE_I,
  input  logic [XLEN/8-1:0]        WB_WR_SEL_I,
  input  logic [REG_ADDR_BITS-1:0] WB_WR_ADR_I,
  input  logic [XLEN-1:0]          WB_WR_DAT_I,
  output logic                     WB_WR_ACK_O,
  input  logic [NUM_GPIOS-1:0]     gpio_in,
  output logic [NUM_GPIOS-1:0]     gpio_out,
  output logic                     int_gen
);

  localparam logic [REG_ADDR_BITS-1:0] BASE_A = REG_ADDR_BITS'(BASE_ADDR);

  logic [NUM_GPIOS-1:0] r_out, r_en, r_mode, r_pol, r_pend;
  logic                 r_int_gen, r_wr_ack, r_rd_ack;
  logic [XLEN-1:0]      r_rd_dat;

  logic [NUM_GPIOS-1:0] w_in_s, w_rise, w_fall, w_evt, w_w1c;
  logic [NUM_GPIOS-1:0] w_lane, w_wdat;
  logic [XLEN-1:0]      w_lane_x, w_rd_val;
  logic                 w_wr_en, w_wr_hit, w_rd_match;
  reg_idx_t             w_wr_idx;

  function automatic logic [NUM_GPIOS-1:0] f_merge(input logic [NUM_GPIOS-1:0] old_v,
                                                   input logic [NUM_GPIOS-1:0] new_v,
                                                   input logic [NUM_GPIOS-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  sync_edge_detect #(
    .WIDTH  (NUM_GPIOS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_in   (gpio_in),
    .o_in_s (w_in_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_wr_en    = WB_WR_STB_I & WB_WR_WE_I;
  assign w_wr_hit   = w_wr_en &&
                      (WB_WR_ADR_I[REG_ADDR_BITS-1:3] == BASE_A[REG_ADDR_BITS-1:3]);
  assign w_rd_match = (WB_RD_ADR_I[REG_ADDR_BITS-1:3] == BASE_A[REG_ADDR_BITS-1:3]);
  assign w_wr_idx   = reg_idx_t'(WB_WR_ADR_I[2:0]);
  assign w_lane_x   = lane_mask(WB_WR_SEL_I);
  assign w_lane     = w_lane_x[NUM_GPIOS-1:0];
  assign w_wdat     = WB_WR_DAT_I[NUM_GPIOS-1:0];
  assign w_w1c      = (w_wr_hit && w_wr_idx == REG_INT_PEND) ? (w_wdat & w_lane) : '0;

  // Edge/level qualification works off the raw synchronised signals, so
  // rewriting mode or polarity cannot manufacture an edge.
  always_comb begin
    w_evt = '0;
    for (int i = 0; i < NUM_GPIOS; i++) begin
      if (r_mode[i] == MODE_EDGE)
        w_evt[i] = (r_pol[i] == POL_ACTIVE_HIGH) ? w_rise[i] : w_fall[i];
      else
        w_evt[i] = (r_pol[i] == POL_ACTIVE_HIGH) ? w_in_s[i] : ~w_in_s[i];
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (w_rd_match) begin
      case (WB_RD_ADR_I[2:0])
        GPIO_OUT_OFS:   w_rd_val = XLEN'(r_out);
        GPIO_IN_OFS:    w_rd_val = XLEN'(w_in_s);
        INT_EN_OFS:     w_rd_val = XLEN'(r_en);
        INT_MODE_OFS:   w_rd_val = XLEN'(r_mode);
        INT_POL_OFS:    w_rd_val = XLEN'(r_pol);
        INT_PEND_OFS:   w_rd_val = XLEN'(r_pend);
        INT_STATUS_OFS: w_rd_val = XLEN'(r_pend & r_en);
        default:        w_rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_en      <= '0;
      r_mode    <= '0;
      r_pol     <= '0;
      r_pend    <= '0;
      r_int_gen <= 1'b0;
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_dat  <= '0;
    end else begin
      r_wr_ack <= w_wr_en;
      r_rd_ack <= WB_RD_STB_I;
      if (WB_RD_STB_I) r_rd_dat <= w_rd_val;
      if (w_wr_hit && w_wr_idx == REG_GPIO_OUT) r_out  <= f_merge(r_out,  w_wdat, w_lane);
      if (w_wr_hit && w_wr_idx == REG_INT_EN)   r_en   <= f_merge(r_en,   w_wdat, w_lane);
      if (w_wr_hit && w_wr_idx == REG_INT_MODE) r_mode <= f_merge(r_mode, w_wdat, w_lane);
      if (w_wr_hit && w_wr_idx == REG_INT_POL)  r_pol  <= f_merge(r_pol,  w_wdat, w_lane);
      // New events are ORed in after the clear so a same-cycle set survives.
      r_pend    <= (r_pend & ~w_w1c) | w_evt;
      r_int_gen <= |(r_pend & r_en);
    end
  end

  assign WB_RD_DAT_O = r_rd_dat;
  assign WB_RD_ACK_O = r_rd_ack;
  assign WB_WR_ACK_O = r_wr_ack;
  assign gpio_out    = r_out;
  assign int_gen     = r_int_gen;

endmodule
